st_window_accum: RTL and testbench

//  Downstream consumer of the 16-bit arithmetic-result Avalon-ST stream.

---
 rtl/st_window_pkg.sv | 15 +
 rtl/st_window_accum_if.sv | 13 +
 rtl/st_out_reg.sv | 44 ++++
 rtl/st_window_accum.sv | 71 +++++++
 tb/tb_st_window_accum.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/st_window_pkg.sv
// Shared sizing and types for the windowed result accumulator.
package st_window_pkg;

   localparam int DATA_W = 16;
   localparam int WINDOW = 16;
   localparam int CNT_W  = $clog2(WINDOW);
   localparam int SUM_W  = DATA_W + CNT_W;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [SUM_W-1:0]  sum_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   localparam cnt_t CNT_LAST = cnt_t'(WINDOW - 1);

endpackage

// File: rtl/st_window_accum_if.sv
// Valid/ready stream carrying one window sum; master drives data/valid, slave drives ready.
interface st_window_accum_if
   import st_window_pkg::*;
();

   sum_t data;
   logic valid;
   logic ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/st_out_reg.sv
// One-entry valid/ready holding register: loads a value, holds it under backpressure, drains on transfer.
module st_out_reg
   import st_window_pkg::*;
(
   input  logic               csi_clk,
   input  logic               rsi_reset_n,
   input  logic               load,
   input  sum_t               load_data,
   st_window_accum_if.master  out_if
);

   logic valid_q, valid_d;
   sum_t data_q,  data_d;

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (valid_q && out_if.ready) begin
         valid_d = 1'b0;
         data_d  = '0;
      end
      // A load on the draining edge wins, so back-to-back sums leave no bubble.
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end
   end

   // NOTE: reset is sampled on the clock edge and state updates use non-blocking assignments.
   always_ff @(posedge csi_clk) begin
      if (!rsi_reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_if.valid = valid_q;
   assign out_if.data  = data_q;

endmodule

// File: rtl/st_window_accum.sv
// Accumulates WINDOW accepted result beats and emits one sum per window.
// Build with WIN_AVG_EN defined to emit the truncated window mean instead of the sum.
module st_window_accum
   import st_window_pkg::*;
(
   input  logic  csi_clk,
   input  logic  rsi_reset_n,
   input  data_t asi_in0_data,
   input  logic  asi_in0_valid,
   output logic  asi_in0_ready,
   output sum_t  aso_out0_data,
   output logic  aso_out0_valid,
   input  logic  aso_out0_ready
);

   st_window_accum_if out_if ();

   sum_t acc_q, acc_d;
   cnt_t cnt_q, cnt_d;
   logic accept;
   logic close;
   sum_t sum_full;
   sum_t load_data;

   assign out_if.ready = aso_out0_ready;
   assign aso_out0_data  = out_if.data;
   assign aso_out0_valid = out_if.valid;

   // Only the closing beat can stall: it needs the output register free or draining.
   assign asi_in0_ready = !(cnt_q == CNT_LAST && out_if.valid && !out_if.ready);
   assign accept        = asi_in0_valid && asi_in0_ready;
   assign close         = accept && (cnt_q == CNT_LAST);
   assign sum_full      = acc_q + sum_t'(asi_in0_data);

`ifdef WIN_AVG_EN
   assign load_data = sum_full >> CNT_W;
`else
   assign load_data = sum_full;
`endif

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (close) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (accept) begin
         acc_d = sum_full;
         cnt_d = cnt_q + cnt_t'(1);
      end
   end

   always_ff @(posedge csi_clk) begin
      if (!rsi_reset_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   st_out_reg u_out_reg (
      .csi_clk     (csi_clk),
      .rsi_reset_n (rsi_reset_n),
      .load        (close),
      .load_data   (load_data),
      .out_if      (out_if)
   );

endmodule

// File: tb/tb_st_window_accum.sv
// Self-checking bench: randomized and directed beats checked against a window-sum reference model.
module tb_st_window_accum;

   localparam int WINDOW = 16;

   logic        csi_clk;
   logic        rsi_reset_n;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;

   st_window_accum_if out_bus ();

   st_window_accum dut (
      .csi_clk        (csi_clk),
      .rsi_reset_n    (rsi_reset_n),
      .asi_in0_data   (in_data),
      .asi_in0_valid  (in_valid),
      .asi_in0_ready  (in_ready),
      .aso_out0_data  (out_bus.data),
      .aso_out0_valid (out_bus.valid),
      .aso_out0_ready (out_bus.ready)
   );

   initial csi_clk = 1'b0;
   always #5 csi_clk = ~csi_clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   int unsigned beats[$];
   int unsigned exp_q[$];
   bit          exp_pending;
   bit          exp_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
   endtask

   // Reference: a window's result is the plain sum of its accepted beats (or that sum divided by WINDOW).
   function automatic int unsigned model_result();
      int unsigned total = 0;
      foreach (beats[i]) total += beats[i];
`ifdef WIN_AVG_EN
      return total / WINDOW;
`else
      return total;
`endif
   endfunction

   // Model update and scoreboard monitor, sampled mid-cycle away from the active edge.
   always @(negedge csi_clk) begin
      if (!rsi_reset_n) begin
         beats.delete();
         exp_q.delete();
      end else begin
         exp_pending = (exp_q.size() > 0);
         exp_ready   = !(beats.size() == WINDOW - 1 && exp_pending && !out_bus.ready);
         check("out_valid", 32'(out_bus.valid), 32'(exp_pending));
         if (out_bus.valid && exp_pending) check("out_data", 32'(out_bus.data), exp_q[0]);
         else if (!out_bus.valid)          check("out_data_idle", 32'(out_bus.data), 32'd0);
         check("in_ready", 32'(in_ready), 32'(exp_ready));
         if (exp_pending && out_bus.ready) void'(exp_q.pop_front());
         if (in_valid && exp_ready) begin
            beats.push_back(int'(in_data));
            if (beats.size() == WINDOW) begin
               exp_q.push_back(model_result());
               beats.delete();
            end
         end
      end
   end

   task automatic do_reset();
      rsi_reset_n = 1'b0;
      in_valid    = 1'b0;
      repeat (3) @(posedge csi_clk);
      #1 rsi_reset_n = 1'b1;
   endtask

   task automatic send_beat(input logic [15:0] d);
      int  n = 0;
      bit  got = 0;
      in_valid = 1'b1;
      in_data  = d;
      do begin
         @(negedge csi_clk);
         got = in_ready;
         @(posedge csi_clk);
         #1 n++;
      end while (!got && n < 64);
      if (!got) begin
         total_cnt++;
         $display("FAIL send_beat_timeout: beat 0x%0h not accepted in %0d cycles, expected acceptance", d, n);
      end
      in_valid = 1'b0;
      in_data  = 16'(($urandom));
   endtask

   task automatic send_window(input logic [15:0] d, input bit rnd);
      for (int i = 0; i < WINDOW; i++) send_beat(rnd ? 16'($urandom) : d);
   endtask

   initial begin
      rsi_reset_n   = 1'b0;
      in_valid      = 1'b0;
      in_data       = '0;
      out_bus.ready = 1'b1;
      @(posedge csi_clk);
      #1 do_reset();
      repeat (2) @(posedge csi_clk);
      #1;

      // Basic window and overflow boundary, sink always ready.
      send_window(16'd1000, 1'b0);
      repeat (2) @(posedge csi_clk);
      #1 send_window(16'hFFFF, 1'b0);
      repeat (2) @(posedge csi_clk);
      #1;

      // Sink stalled across two windows; only the second closing beat stalls.
      out_bus.ready = 1'b0;
      send_window(16'd0, 1'b1);
      for (int i = 0; i < WINDOW - 1; i++) send_beat(16'($urandom));
      fork
         send_beat(16'h1234);
         begin
            repeat (5) @(posedge csi_clk);
            #1 out_bus.ready = 1'b1;
         end
      join
      repeat (3) @(posedge csi_clk);
      #1;

      // Drain and reload on the same edge.
      out_bus.ready = 1'b0;
      send_window(16'd7, 1'b0);
      for (int i = 0; i < WINDOW - 1; i++) send_beat(16'd3);
      out_bus.ready = 1'b1;
      send_beat(16'd3);
      repeat (3) @(posedge csi_clk);
      #1;

      // Reset mid-window discards the partial sum.
      for (int i = 0; i < 7; i++) send_beat(16'd5);
      do_reset();
      send_window(16'd5, 1'b0);
      repeat (3) @(posedge csi_clk);
      #1;

      // Reset with a sum stuck in the output register.
      out_bus.ready = 1'b0;
      send_window(16'd9, 1'b0);
      for (int i = 0; i < 4; i++) send_beat(16'd9);
      do_reset();
      out_bus.ready = 1'b1;

      // Randomized traffic with random backpressure and one reset.
      for (int c = 0; c < 3000; c++) begin
         in_valid      = ($urandom_range(0, 3) != 0);
         in_data       = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         out_bus.ready = ($urandom_range(0, 2) != 0);
         @(posedge csi_clk);
         #1;
         if (c == 1500) do_reset();
      end

      in_valid      = 1'b0;
      out_bus.ready = 1'b1;
      repeat (4) @(posedge csi_clk);
      #1 check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
